mc_controller: RTL and testbench

//  Parametrised multicycle control FSM for the 16-bit TF datapath: fetch, decode, execute, writeback.

---
 rtl/mc_pkg.sv | 102 ++++++++++
 rtl/mc_alu_decode.sv | 33 +++
 rtl/mc_controller.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle TF controller.
// Holds the state enum, the instruction field codes, the ALU/pc_en codes and the decode-step helper.
package mc_pkg;

    typedef enum logic [4:0] {
        S_PCINC,  S_FETCH,  S_DECODE, S_RTYPE,  S_ITYPE,  S_MOV,
        S_SCOND,  S_LSH,    S_LSHI,   S_SAR,    S_LUI,    S_MOVI,
        S_WB,     S_LOAD,   S_LD_WB,  S_STORE,  S_ST_DONE,
        S_JCOND,  S_JC_PC,  S_BCOND,  S_BR_PC,  S_JAL,    S_JAL_PC,
        S_ERR
    } state_t;

    // Every datapath strobe/select except the parametric-width alu_op.
    typedef struct packed {
        logic [1:0] pc_en;
        logic       pc_src;
        logic       ir_en;
        logic       mdr_en;
        logic       rf_we;
        logic       out_en;
        logic       b_sel;
        logic       ext_imm;
        logic       shift_arith;
        logic       mem_req;
        logic       mem_we;
        logic       mem_adr_sel;
        logic [1:0] a_sel;
        logic [1:0] rf_wsel;
        logic [1:0] out_sel;
        logic [1:0] shamt_sel;
        logic [1:0] shsrc_sel;
    } ctrl_t;

    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_SHIFT  = 4'b1000;
    localparam logic [3:0] OP_BCOND  = 4'b1100;
    localparam logic [3:0] OP_LUI    = 4'b1111;
    localparam logic [3:0] OP_MOVI   = 4'b1011;

    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STORE = 4'b0100;
    localparam logic [3:0] EXT_SCOND = 4'b1101;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_SAR   = 4'b1000;

    // ALU function field, shared by R-type opcode_ext and I-type opcode.
    localparam logic [3:0] FN_AND    = 4'b0001;
    localparam logic [3:0] FN_OR     = 4'b0010;
    localparam logic [3:0] FN_XOR    = 4'b0011;
    localparam logic [3:0] FN_ADD    = 4'b0101;
    localparam logic [3:0] FN_ADDU   = 4'b0110;
    localparam logic [3:0] FN_ADDC   = 4'b0111;
    localparam logic [3:0] FN_SUB    = 4'b1001;
    localparam logic [3:0] FN_SUBC   = 4'b1010;
    localparam logic [3:0] FN_CMP    = 4'b1011;

    localparam logic [2:0] ALU_CMP   = 3'd0;
    localparam logic [2:0] ALU_AND   = 3'd1;
    localparam logic [2:0] ALU_OR    = 3'd2;
    localparam logic [2:0] ALU_ADD   = 3'd3;
    localparam logic [2:0] ALU_ADDC  = 3'd4;
    localparam logic [2:0] ALU_SUB   = 3'd5;
    localparam logic [2:0] ALU_SUBC  = 3'd6;
    localparam logic [2:0] ALU_XOR   = 3'd7;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_PCINC  = 2'b01;
    localparam logic [1:0] PC_LOAD   = 2'b10;
    localparam logic [1:0] PC_INC    = 2'b11;

    function automatic state_t decode_next(logic [3:0] op, logic [3:0] ext);
        state_t s;
        case (op)
            OP_RTYPE: s = (ext == EXT_MOV) ? S_MOV : S_RTYPE;
            OP_MEM: begin
                case (ext)
                    EXT_LOAD:  s = S_LOAD;
                    EXT_STORE: s = S_STORE;
                    EXT_SCOND: s = S_SCOND;
                    EXT_JCOND: s = S_JCOND;
                    default:   s = S_JAL;
                endcase
            end
            OP_SHIFT: begin
                case (ext)
                    EXT_LSH: s = S_LSH;
                    EXT_SAR: s = S_SAR;
                    default: s = S_LSHI;
                endcase
            end
            OP_BCOND: s = S_BCOND;
            OP_LUI:   s = S_LUI;
            OP_MOVI:  s = S_MOVI;
            default:  s = S_ITYPE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU-function decode: R-type uses opcode_ext, I-type uses opcode.
// ADDC has no immediate form, so the I-type slot falls back to ADD.
module mc_alu_decode
    import mc_pkg::*;
#(
    parameter int ALU_OP_W = 5
) (
    input  logic [3:0]          opcode,
    input  logic [3:0]          opcode_ext,
    input  logic                is_rtype,
    output logic [ALU_OP_W-1:0] alu_op
);

    logic [3:0] fn;
    logic [2:0] code;

    always_comb begin
        fn = is_rtype ? opcode_ext : opcode;
        case (fn)
            FN_CMP:          code = ALU_CMP;
            FN_AND:          code = ALU_AND;
            FN_OR:           code = ALU_OR;
            FN_XOR:          code = ALU_XOR;
            FN_ADD, FN_ADDU: code = ALU_ADD;
            FN_ADDC:         code = is_rtype ? ALU_ADDC : ALU_ADD;
            FN_SUB:          code = ALU_SUB;
            FN_SUBC:         code = ALU_SUBC;
            default:         code = ALU_ADD;
        endcase
        alu_op = ALU_OP_W'(code);
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle fetch/decode/execute/writeback controller for the 16-bit TF datapath,
// with a memory handshake, per-access wait timeout, fetch stall and retired-instruction count.
module mc_controller
    import mc_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ALU_OP_W    = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                mem_ready,
    input  logic [3:0]          opcode,
    input  logic [3:0]          opcode_ext,
    input  logic [WIDTH-1:0]    cond_codes,
    output logic [1:0]          pc_en,
    output logic                pc_src,
    output logic                ir_en,
    output logic                mdr_en,
    output logic                rf_we,
    output logic                out_en,
    output logic                b_sel,
    output logic                ext_imm,
    output logic                shift_arith,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_adr_sel,
    output logic [1:0]          a_sel,
    output logic [1:0]          rf_wsel,
    output logic [1:0]          out_sel,
    output logic [1:0]          shamt_sel,
    output logic [1:0]          shsrc_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_err,
    output logic [CNT_W-1:0]    retired_cnt
);

    // state            | meaning
    // PCINC            | post-reset PC step, then fetch
    // FETCH            | instruction read (held while stall)
    // DECODE           | route on opcode/opcode_ext
    // RTYPE..MOVI      | single-cycle execute, then WB
    // WB / LD_WB       | register write + PC increment, retire
    // LOAD/STORE/ST_DONE | data access and its completion
    // JCOND/JC_PC, BCOND/BR_PC, JAL/JAL_PC | target compute, then PC update + retire
    // ERR              | memory timeout, frozen until reset

    state_t                state, state_next;
    logic [TO_W-1:0]       wait_cnt, wait_next;
    logic                  wait_expired;
    logic                  retire;
    logic                  is_rtype;
    logic                  unused_cc;
    logic [ALU_OP_W-1:0]   alu_dec, alu_c;
    ctrl_t                 ctrl_c, ctrl;

    mc_alu_decode #(.ALU_OP_W(ALU_OP_W)) u_alu_decode (
        .opcode     (opcode),
        .opcode_ext (opcode_ext),
        .is_rtype   (is_rtype),
        .alu_op     (alu_dec)
    );

    assign is_rtype     = (state == S_RTYPE);
    assign wait_expired = (wait_cnt == TO_W'(MEM_TIMEOUT));
    assign unused_cc    = ^cond_codes[WIDTH-1:1];

    always_comb begin
        state_next = state;
        ctrl_c     = '0;
        alu_c      = '0;
        retire     = 1'b0;
        case (state)
            S_PCINC: begin
                ctrl_c.pc_en = PC_PCINC;
                state_next   = S_FETCH;
            end
            S_FETCH: begin
                if (!stall) begin
                    ctrl_c.mem_req = 1'b1;
                    ctrl_c.ir_en   = mem_ready;
                    if (mem_ready)         state_next = S_DECODE;
                    else if (wait_expired) state_next = S_ERR;
                end
            end
            S_DECODE: state_next = decode_next(opcode, opcode_ext);
            S_RTYPE, S_ITYPE: begin
                ctrl_c.a_sel   = 2'd1;
                ctrl_c.b_sel   = 1'b1;
                ctrl_c.out_sel = 2'd1;
                ctrl_c.out_en  = 1'b1;
                alu_c          = alu_dec;
                state_next     = S_WB;
            end
            S_MOV: begin
                ctrl_c.shsrc_sel = 2'd2;
                ctrl_c.shamt_sel = 2'd3;
                ctrl_c.out_en    = 1'b1;
                state_next       = S_WB;
            end
            S_SCOND: begin
                ctrl_c.out_sel = 2'd2;
                ctrl_c.out_en  = 1'b1;
                state_next     = S_WB;
            end
            S_LSH: begin
                ctrl_c.out_en = 1'b1;
                state_next    = S_WB;
            end
            S_LSHI: begin
                ctrl_c.shamt_sel = 2'd1;
                ctrl_c.ext_imm   = 1'b1;
                ctrl_c.out_en    = 1'b1;
                state_next       = S_WB;
            end
            S_SAR: begin
                ctrl_c.shift_arith = 1'b1;
                ctrl_c.out_en      = 1'b1;
                state_next         = S_WB;
            end
            S_LUI: begin
                ctrl_c.shamt_sel = 2'd2;
                ctrl_c.shsrc_sel = 2'd1;
                ctrl_c.out_en    = 1'b1;
                state_next       = S_WB;
            end
            S_MOVI: begin
                ctrl_c.shamt_sel = 2'd3;
                ctrl_c.shsrc_sel = 2'd1;
                ctrl_c.out_en    = 1'b1;
                state_next       = S_WB;
            end
            S_WB: begin
                ctrl_c.rf_wsel = 2'd1;
                ctrl_c.rf_we   = 1'b1;
                ctrl_c.pc_en   = PC_INC;
                retire         = 1'b1;
                state_next     = S_FETCH;
            end
            S_LOAD: begin
                ctrl_c.mem_req     = 1'b1;
                ctrl_c.mem_adr_sel = 1'b1;
                ctrl_c.mdr_en      = mem_ready;
                if (mem_ready)         state_next = S_LD_WB;
                else if (wait_expired) state_next = S_ERR;
            end
            S_LD_WB: begin
                ctrl_c.rf_we = 1'b1;
                ctrl_c.pc_en = PC_INC;
                retire       = 1'b1;
                state_next   = S_FETCH;
            end
            S_STORE: begin
                ctrl_c.mem_req     = 1'b1;
                ctrl_c.mem_we      = 1'b1;
                ctrl_c.mem_adr_sel = 1'b1;
                if (mem_ready)         state_next = S_ST_DONE;
                else if (wait_expired) state_next = S_ERR;
            end
            S_ST_DONE: begin
                ctrl_c.pc_en = PC_INC;
                retire       = 1'b1;
                state_next   = S_FETCH;
            end
            S_JCOND: begin
                ctrl_c.shamt_sel = 2'd3;
                ctrl_c.shsrc_sel = 2'd2;
                ctrl_c.out_en    = 1'b1;
                state_next       = S_JC_PC;
            end
            S_JC_PC: begin
                ctrl_c.pc_src = cond_codes[0];
                ctrl_c.pc_en  = PC_LOAD;
                retire        = 1'b1;
                state_next    = S_FETCH;
            end
            S_BCOND: begin
                ctrl_c.shamt_sel = 2'd3;
                ctrl_c.shsrc_sel = 2'd1;
                ctrl_c.out_en    = 1'b1;
                state_next       = S_BR_PC;
            end
            S_BR_PC: begin
                ctrl_c.pc_src = cond_codes[0];
                ctrl_c.pc_en  = PC_INC;
                retire        = 1'b1;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                ctrl_c.shamt_sel = 2'd3;
                ctrl_c.shsrc_sel = 2'd2;
                ctrl_c.out_en    = 1'b1;
                ctrl_c.rf_wsel   = 2'd2;
                ctrl_c.rf_we     = 1'b1;
                state_next       = S_JAL_PC;
            end
            S_JAL_PC: begin
                ctrl_c.pc_src = 1'b1;
                ctrl_c.pc_en  = PC_LOAD;
                retire        = 1'b1;
                state_next    = S_FETCH;
            end
            S_ERR: state_next = S_ERR;
            default: begin
                ctrl_c.pc_en = PC_HOLD;
                state_next   = S_PCINC;
            end
        endcase
    end

    // Outputs are forced low while reset is held so a pending memory request drops at once.
    assign ctrl   = reset ? '0 : ctrl_c;
    assign alu_op = reset ? '0 : alu_c;

    assign pc_en       = ctrl.pc_en;
    assign pc_src      = ctrl.pc_src;
    assign ir_en       = ctrl.ir_en;
    assign mdr_en      = ctrl.mdr_en;
    assign rf_we       = ctrl.rf_we;
    assign out_en      = ctrl.out_en;
    assign b_sel       = ctrl.b_sel;
    assign ext_imm     = ctrl.ext_imm;
    assign shift_arith = ctrl.shift_arith;
    assign mem_req     = ctrl.mem_req;
    assign mem_we      = ctrl.mem_we;
    assign mem_adr_sel = ctrl.mem_adr_sel;
    assign a_sel       = ctrl.a_sel;
    assign rf_wsel     = ctrl.rf_wsel;
    assign out_sel     = ctrl.out_sel;
    assign shamt_sel   = ctrl.shamt_sel;
    assign shsrc_sel   = ctrl.shsrc_sel;

    // Any state change restarts the wait budget; stalled fetch cycles leave it untouched.
    always_comb begin
        if (state_next != state)
            wait_next = '0;
        else if (ctrl.mem_req && !mem_ready)
            wait_next = wait_cnt + 1'b1;
        else
            wait_next = wait_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_PCINC;
            wait_cnt    <= '0;
            retired_cnt <= '0;
            mem_err     <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (retire)
                retired_cnt <= retired_cnt + 1'b1;
            if (state_next == S_ERR)
                mem_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction table, corner-case sequences
// and random instruction streams against an instruction-level reference model.
module tb_mc_controller;

    localparam int WIDTH       = 16;
    localparam int ALU_OP_W    = 5;
    localparam int MEM_TIMEOUT = 15;
    localparam int TO_W        = 4;
    localparam int CNT_W       = 4;

    typedef struct packed {
        logic [1:0] pc_en;
        logic       pc_src;
        logic       ir_en;
        logic       mdr_en;
        logic       rf_we;
        logic       out_en;
        logic       b_sel;
        logic       ext_imm;
        logic       shift_arith;
        logic       mem_req;
        logic       mem_we;
        logic       mem_adr_sel;
        logic [1:0] a_sel;
        logic [1:0] rf_wsel;
        logic [1:0] out_sel;
        logic [1:0] shamt_sel;
        logic [1:0] shsrc_sel;
        logic [4:0] alu_op;
    } outs_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] ext;
        logic       cc;
        logic [4:0] exp_alu;
        logic       exp_pc_src;
    } vec_t;

    // ALU code per function field, index = field value.
    localparam logic [4:0] ALU_R [16] = '{5'd3, 5'd1, 5'd2, 5'd7, 5'd3, 5'd3, 5'd3, 5'd4,
                                          5'd3, 5'd5, 5'd6, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3};
    localparam logic [4:0] ALU_I [16] = '{5'd3, 5'd1, 5'd2, 5'd7, 5'd3, 5'd3, 5'd3, 5'd3,
                                          5'd3, 5'd5, 5'd6, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3};

    logic                clk;
    logic                reset;
    logic                stall;
    logic                mem_ready;
    logic [3:0]          opcode;
    logic [3:0]          opcode_ext;
    logic [WIDTH-1:0]    cond_codes;
    logic [1:0]          pc_en;
    logic                pc_src, ir_en, mdr_en, rf_we, out_en, b_sel, ext_imm, shift_arith;
    logic                mem_req, mem_we, mem_adr_sel;
    logic [1:0]          a_sel, rf_wsel, out_sel, shamt_sel, shsrc_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_err;
    logic [CNT_W-1:0]    retired_cnt;

    outs_t            act;
    outs_t            last_act;
    logic [CNT_W-1:0] model_ret;
    logic             model_err;
    int               vectors;
    int               miscompares;

    mc_controller #(
        .WIDTH(WIDTH), .ALU_OP_W(ALU_OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .mem_ready(mem_ready),
        .opcode(opcode), .opcode_ext(opcode_ext), .cond_codes(cond_codes),
        .pc_en(pc_en), .pc_src(pc_src), .ir_en(ir_en), .mdr_en(mdr_en), .rf_we(rf_we),
        .out_en(out_en), .b_sel(b_sel), .ext_imm(ext_imm), .shift_arith(shift_arith),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr_sel(mem_adr_sel),
        .a_sel(a_sel), .rf_wsel(rf_wsel), .out_sel(out_sel), .shamt_sel(shamt_sel),
        .shsrc_sel(shsrc_sel), .alu_op(alu_op), .mem_err(mem_err), .retired_cnt(retired_cnt)
    );

    assign act = {pc_en, pc_src, ir_en, mdr_en, rf_we, out_en, b_sel, ext_imm, shift_arith,
                  mem_req, mem_we, mem_adr_sel, a_sel, rf_wsel, out_sel, shamt_sel, shsrc_sel,
                  alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Expected strobes for one cycle of a named step of the instruction flow.
    function automatic outs_t outs_of(string s, logic rdy);
        outs_t o;
        o = '0;
        case (s)
            "PCINC":  o.pc_en = 2'b01;
            "FETCH":  begin o.mem_req = 1'b1; o.ir_en = rdy; end
            "RTYPE":  begin o.a_sel = 2'd1; o.b_sel = 1'b1; o.out_sel = 2'd1; o.out_en = 1'b1;
                            o.alu_op = ALU_R[opcode_ext]; end
            "ITYPE":  begin o.a_sel = 2'd1; o.b_sel = 1'b1; o.out_sel = 2'd1; o.out_en = 1'b1;
                            o.alu_op = ALU_I[opcode]; end
            "MOV":    begin o.shsrc_sel = 2'd2; o.shamt_sel = 2'd3; o.out_en = 1'b1; end
            "SCOND":  begin o.out_sel = 2'd2; o.out_en = 1'b1; end
            "LSH":    o.out_en = 1'b1;
            "LSHI":   begin o.shamt_sel = 2'd1; o.ext_imm = 1'b1; o.out_en = 1'b1; end
            "SAR":    begin o.shift_arith = 1'b1; o.out_en = 1'b1; end
            "LUI":    begin o.shamt_sel = 2'd2; o.shsrc_sel = 2'd1; o.out_en = 1'b1; end
            "MOVI":   begin o.shamt_sel = 2'd3; o.shsrc_sel = 2'd1; o.out_en = 1'b1; end
            "WB":     begin o.rf_wsel = 2'd1; o.rf_we = 1'b1; o.pc_en = 2'b11; end
            "LOAD":   begin o.mem_req = 1'b1; o.mem_adr_sel = 1'b1; o.mdr_en = rdy; end
            "LD_WB":  begin o.rf_we = 1'b1; o.pc_en = 2'b11; end
            "STORE":  begin o.mem_req = 1'b1; o.mem_we = 1'b1; o.mem_adr_sel = 1'b1; end
            "ST_DONE": o.pc_en = 2'b11;
            "JCOND":  begin o.shamt_sel = 2'd3; o.shsrc_sel = 2'd2; o.out_en = 1'b1; end
            "JC_PC":  begin o.pc_src = cond_codes[0]; o.pc_en = 2'b10; end
            "BCOND":  begin o.shamt_sel = 2'd3; o.shsrc_sel = 2'd1; o.out_en = 1'b1; end
            "BR_PC":  begin o.pc_src = cond_codes[0]; o.pc_en = 2'b11; end
            "JAL":    begin o.shamt_sel = 2'd3; o.shsrc_sel = 2'd2; o.out_en = 1'b1;
                            o.rf_wsel = 2'd2; o.rf_we = 1'b1; end
            "JAL_PC": begin o.pc_src = 1'b1; o.pc_en = 2'b10; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic string decode_kind(logic [3:0] op, logic [3:0] ext);
        if (op == 4'd0)  return (ext == 4'd13) ? "MOV" : "RTYPE";
        if (op == 4'd4) begin
            if (ext == 4'd0)  return "LOAD";
            if (ext == 4'd4)  return "STORE";
            if (ext == 4'd13) return "SCOND";
            if (ext == 4'd12) return "JCOND";
            return "JAL";
        end
        if (op == 4'd8) begin
            if (ext == 4'd4) return "LSH";
            if (ext == 4'd8) return "SAR";
            return "LSHI";
        end
        if (op == 4'd12) return "BCOND";
        if (op == 4'd15) return "LUI";
        if (op == 4'd11) return "MOVI";
        return "ITYPE";
    endfunction

    // One clock of checking: compare at the falling edge, then move to just after the rising edge.
    task automatic step(input string nm);
        outs_t exp;
        exp = outs_of(nm, mem_ready);
        @(negedge clk);
        vectors++;
        last_act = act;
        if (act !== exp || retired_cnt !== model_ret || mem_err !== model_err) begin
            miscompares++;
            $display("FAIL %s @%0t: got outs=%h retired=%0d mem_err=%b, required outs=%h retired=%0d mem_err=%b",
                     nm, $time, act, retired_cnt, mem_err, exp, model_ret, model_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input string nm, input int lat);
        for (int i = 0; i < lat; i++) begin
            mem_ready = 1'b0;
            step(nm);
        end
        mem_ready = 1'b1;
        step(nm);
    endtask

    task automatic check_val(input string nm, input int got, input int req);
        vectors++;
        if (got != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        model_ret = '0;
        model_err = 1'b0;
        step("RESET");
        reset = 1'b0;
        step("PCINC");
    endtask

    // Runs one instruction starting in fetch; reports alu_op of the first execute cycle
    // and pc_src of the retire cycle.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] ext, input logic cc,
                             input int stall_n, input int flat, input int mlat,
                             output logic [4:0] alu_seen, output logic pc_src_seen);
        string kind;
        string fin;
        opcode     = op;
        opcode_ext = ext;
        cond_codes = WIDTH'($urandom);
        cond_codes[0] = cc;
        stall = 1'b1;
        for (int i = 0; i < stall_n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            step("STALL");
        end
        stall = 1'b0;
        mem_phase("FETCH", flat);
        mem_ready = 1'($urandom_range(0, 1));
        step("DECODE");
        kind = decode_kind(op, ext);
        if (kind == "LOAD" || kind == "STORE") begin
            mem_phase(kind, mlat);
            alu_seen = last_act.alu_op;
            fin = (kind == "LOAD") ? "LD_WB" : "ST_DONE";
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            step(kind);
            alu_seen = last_act.alu_op;
            if (kind == "JCOND")      fin = "JC_PC";
            else if (kind == "BCOND") fin = "BR_PC";
            else if (kind == "JAL")   fin = "JAL_PC";
            else                      fin = "WB";
        end
        mem_ready = 1'($urandom_range(0, 1));
        step(fin);
        pc_src_seen = last_act.pc_src;
        model_ret = model_ret + 1'b1;
    endtask

    vec_t       tab [23];
    logic [4:0] alu_seen;
    logic       pcs_seen;

    initial begin
        tab[0]  = '{4'd0,  4'd5,  1'b0, 5'd3, 1'b0};
        tab[1]  = '{4'd0,  4'd7,  1'b0, 5'd4, 1'b0};
        tab[2]  = '{4'd0,  4'd11, 1'b0, 5'd0, 1'b0};
        tab[3]  = '{4'd0,  4'd3,  1'b0, 5'd7, 1'b0};
        tab[4]  = '{4'd0,  4'd9,  1'b1, 5'd5, 1'b0};
        tab[5]  = '{4'd0,  4'd13, 1'b0, 5'd0, 1'b0};
        tab[6]  = '{4'd7,  4'd0,  1'b0, 5'd3, 1'b0};
        tab[7]  = '{4'd1,  4'd2,  1'b0, 5'd1, 1'b0};
        tab[8]  = '{4'd10, 4'd0,  1'b0, 5'd6, 1'b0};
        tab[9]  = '{4'd2,  4'd0,  1'b1, 5'd2, 1'b0};
        tab[10] = '{4'd4,  4'd0,  1'b1, 5'd0, 1'b0};
        tab[11] = '{4'd4,  4'd4,  1'b1, 5'd0, 1'b0};
        tab[12] = '{4'd4,  4'd13, 1'b1, 5'd0, 1'b0};
        tab[13] = '{4'd4,  4'd12, 1'b1, 5'd0, 1'b1};
        tab[14] = '{4'd4,  4'd12, 1'b0, 5'd0, 1'b0};
        tab[15] = '{4'd4,  4'd3,  1'b0, 5'd0, 1'b1};
        tab[16] = '{4'd8,  4'd4,  1'b0, 5'd0, 1'b0};
        tab[17] = '{4'd8,  4'd8,  1'b0, 5'd0, 1'b0};
        tab[18] = '{4'd8,  4'd1,  1'b0, 5'd0, 1'b0};
        tab[19] = '{4'd12, 4'd0,  1'b1, 5'd0, 1'b1};
        tab[20] = '{4'd12, 4'd0,  1'b0, 5'd0, 1'b0};
        tab[21] = '{4'd15, 4'd0,  1'b0, 5'd0, 1'b0};
        tab[22] = '{4'd11, 4'd0,  1'b0, 5'd0, 1'b0};

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        mem_ready   = 1'b0;
        opcode      = '0;
        opcode_ext  = '0;
        cond_codes  = '0;
        model_ret   = '0;
        model_err   = 1'b0;
        @(posedge clk);
        #1;
        step("RESET");
        reset = 1'b0;
        step("PCINC");

        // ADD with immediate ready: first retire brings the counter to 1.
        run_instr(4'd0, 4'd5, 1'b0, 0, 0, 0, alu_seen, pcs_seen);
        mem_ready = 1'b0;
        opcode = 4'd1;
        step("FETCH");
        check_val("retired_after_add", int'(retired_cnt), 1);
        mem_ready = 1'b1;
        step("FETCH");
        mem_ready = 1'b0;
        step("DECODE");
        step("ITYPE");
        step("WB");
        model_ret = model_ret + 1'b1;

        for (int i = 0; i < 23; i++) begin
            run_instr(tab[i].op, tab[i].ext, tab[i].cc, 0, 0, 0, alu_seen, pcs_seen);
            check_val($sformatf("alu_tab%0d", i), int'(alu_seen), int'(tab[i].exp_alu));
            check_val($sformatf("pcsrc_tab%0d", i), int'(pcs_seen), int'(tab[i].exp_pc_src));
        end

        // Load with three-cycle memory delay, stall of five, fetch at the timeout boundary.
        run_instr(4'd4, 4'd0, 1'b0, 0, 0, 3, alu_seen, pcs_seen);
        run_instr(4'd5, 4'd0, 1'b0, 5, 0, 0, alu_seen, pcs_seen);
        run_instr(4'd4, 4'd4, 1'b0, 0, MEM_TIMEOUT, MEM_TIMEOUT, alu_seen, pcs_seen);
        run_instr(4'd12, 4'd0, 1'b1, 0, 1, 0, alu_seen, pcs_seen);
        check_val("bcond_cc1", int'(pcs_seen), 1);
        run_instr(4'd12, 4'd0, 1'b0, 0, 1, 0, alu_seen, pcs_seen);
        check_val("bcond_cc0", int'(pcs_seen), 0);

        for (int n = 0; n < 120; n++) begin
            logic [3:0] rop;
            int sn, fl, ml;
            rop = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2) * 4) : 4'($urandom_range(0, 15));
            sn  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_TIMEOUT) : $urandom_range(0, 2);
            ml  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MEM_TIMEOUT) : $urandom_range(0, 2);
            run_instr(rop, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), sn, fl, ml,
                      alu_seen, pcs_seen);
        end

        // Fetch that never completes: error after MEM_TIMEOUT+1 waiting cycles, sticky until reset.
        stall     = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i <= MEM_TIMEOUT; i++) step("FETCH");
        model_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            stall     = 1'($urandom_range(0, 1));
            step("ERR");
        end
        stall = 1'b0;
        do_reset();

        // Reset in the middle of a store.
        run_instr(4'd0, 4'd2, 1'b0, 0, 0, 0, alu_seen, pcs_seen);
        opcode     = 4'd4;
        opcode_ext = 4'd4;
        mem_ready  = 1'b1;
        step("FETCH");
        mem_ready = 1'b0;
        step("DECODE");
        step("STORE");
        step("STORE");
        do_reset();
        run_instr(4'd0, 4'd5, 1'b0, 0, 0, 0, alu_seen, pcs_seen);
        mem_ready = 1'b0;
        step("FETCH");
        check_val("retired_after_reset_add", int'(retired_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
